// File: rtl/nubus_ad_oe_seq.sv
// nubus_ad_oe_seq - output-enable sequencer for the NuBus AD-line bus switches.
//
// Grants the AD lines to one direction at a time (outbound drive or inbound
// listen). Every enable is preceded by DEAD_CYCLES cycles with all OEs high.
// The two switch sets are never enabled in the same cycle.
//
// Optional feature macro: NUBUS_OE_WATCHDOG_EN
//   defined   - a drive watchdog forces DRIVE back to IDLE after MAX_DRIVE
//               cycles, pulses err_watchdog and locks out new drive grants
//               until req_out is seen low.
//   undefined - no watchdog counter or lockout; err_watchdog is tied low.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | all OEs high, arbitrating between req_out and req_in
// DEAD   | direction chosen, all OEs high, counting out the dead time
// DRIVE  | outbound switches enabled on the latched lane mask, gnt_out
// LISTEN | all inbound switches enabled, gnt_in

module nubus_ad_oe_seq #(
    parameter int LANES       = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_DRIVE   = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             req_out,
    input  logic             req_in,
    input  logic [LANES-1:0] lane_mask,
    output logic             gnt_out,
    output logic             gnt_in,
    output logic [LANES-1:0] oe_out_n,
    output logic [LANES-1:0] oe_in_n,
    output logic             busy,
    output logic             err_watchdog
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEAD   = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_LISTEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_OUT = 1'b0,
        DIR_IN  = 1'b1
    } dir_t;

    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DCW-1:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? DCW'(DEAD_CYCLES - 1) : '0;

    // Reject parameter values the sequencing cannot honour.
    if (LANES < 1 || DEAD_CYCLES < 0 || MAX_DRIVE < 2) begin : g_param_check
        $error("nubus_ad_oe_seq: illegal parameter value");
    end

    state_t           state;
    dir_t             dir;
    logic [LANES-1:0] mask_q;
    logic [DCW-1:0]   dead_cnt;
    logic             prio_out;     // 1: outbound wins a tie
    logic             lockout;
    logic             wd_expire;

    logic             out_valid;
    logic             in_valid;
    logic             pick_out;
    logic             any_valid;
    logic             dir_req;

    // Request qualification and tie-break for the IDLE decision.
    always_comb begin
        out_valid = req_out && (|lane_mask) && !lockout;
        in_valid  = req_in;
        any_valid = out_valid || in_valid;
        pick_out  = out_valid && (!in_valid || prio_out);
        dir_req   = (dir == DIR_OUT) ? req_out : req_in;
    end

`ifdef NUBUS_OE_WATCHDOG_EN
    localparam int WDW = (MAX_DRIVE > 1) ? $clog2(MAX_DRIVE) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_DRIVE - 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_expire = (state == ST_DRIVE) && (wd_cnt == WD_LAST);

    // Drive-age counter, lockout flag and the one-cycle error pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wd_cnt       <= '0;
            lockout      <= 1'b0;
            err_watchdog <= 1'b0;
        end else begin
            err_watchdog <= wd_expire;
            // Held at zero outside DRIVE so every DRIVE entry starts fresh.
            if (state != ST_DRIVE || wd_expire) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WDW'(1);
            end
            if (wd_expire) begin
                lockout <= 1'b1;
            end else if (!req_out) begin
                lockout <= 1'b0;
            end
        end
    end
`else
    assign wd_expire    = 1'b0;
    assign lockout      = 1'b0;
    assign err_watchdog = 1'b0;
`endif

    // Sequencer: state, latched direction/mask and all registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            dir      <= DIR_OUT;
            mask_q   <= '0;
            dead_cnt <= '0;
            prio_out <= 1'b1;
            oe_out_n <= '1;
            oe_in_n  <= '1;
            gnt_out  <= 1'b0;
            gnt_in   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Everything disabled unless the branch below keeps a path open.
            oe_out_n <= '1;
            oe_in_n  <= '1;
            gnt_out  <= 1'b0;
            gnt_in   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (any_valid) begin
                        dir    <= pick_out ? DIR_OUT : DIR_IN;
                        mask_q <= pick_out ? lane_mask : '1;
                        busy   <= 1'b1;
                        if (DEAD_CYCLES == 0) begin
                            if (pick_out) begin
                                state    <= ST_DRIVE;
                                oe_out_n <= ~lane_mask;
                                gnt_out  <= 1'b1;
                            end else begin
                                state   <= ST_LISTEN;
                                oe_in_n <= '0;
                                gnt_in  <= 1'b1;
                            end
                        end else begin
                            state    <= ST_DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                end

                ST_DEAD: begin
                    // A dropped request abandons the grant; the other one waits for IDLE.
                    if (!dir_req) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (dead_cnt == '0) begin
                        if (dir == DIR_OUT) begin
                            state    <= ST_DRIVE;
                            oe_out_n <= ~mask_q;
                            gnt_out  <= 1'b1;
                        end else begin
                            state   <= ST_LISTEN;
                            oe_in_n <= '0;
                            gnt_in  <= 1'b1;
                        end
                    end else begin
                        dead_cnt <= dead_cnt - DCW'(1);
                    end
                end

                ST_DRIVE: begin
                    if (!req_out || wd_expire) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        prio_out <= ~prio_out;
                    end else begin
                        oe_out_n <= ~mask_q;
                        gnt_out  <= 1'b1;
                    end
                end

                ST_LISTEN: begin
                    if (!req_in) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        prio_out <= ~prio_out;
                    end else begin
                        oe_in_n <= '0;
                        gnt_in  <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bus contention guard: one switch set must be fully off at all times.
    a_oe_exclusive: assert property (@(posedge sys_clk) disable iff (sys_rst)
        (&oe_out_n) || (&oe_in_n))
        else $fatal(1, "nubus_ad_oe_seq: outbound and inbound OEs enabled together");

endmodule

// File: tb/tb_nubus_ad_oe_seq.sv
// Bench for nubus_ad_oe_seq: two instances (DEAD_CYCLES 2 and 0) share the
// same directed stimulus and are checked every cycle against a behavioural
// model, plus literal expectations at hand-computed cycles.
module tb_nubus_ad_oe_seq;

    localparam int MAXD = 8;
`ifdef NUBUS_OE_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       req_out = 1'b0;
    logic       req_in  = 1'b0;
    logic [3:0] lane_mask = 4'h0;

    logic       gnt_out0, gnt_in0, busy0, err0;
    logic [3:0] oe_out_n0, oe_in_n0;
    logic       gnt_out1, gnt_in1, busy1, err1;
    logic [3:0] oe_out_n1, oe_in_n1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    nubus_ad_oe_seq #(.LANES(4), .DEAD_CYCLES(2), .MAX_DRIVE(MAXD)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req_out(req_out), .req_in(req_in),
        .lane_mask(lane_mask), .gnt_out(gnt_out0), .gnt_in(gnt_in0),
        .oe_out_n(oe_out_n0), .oe_in_n(oe_in_n0), .busy(busy0), .err_watchdog(err0));

    nubus_ad_oe_seq #(.LANES(4), .DEAD_CYCLES(0), .MAX_DRIVE(MAXD)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req_out(req_out), .req_in(req_in),
        .lane_mask(lane_mask), .gnt_out(gnt_out1), .gnt_in(gnt_in1),
        .oe_out_n(oe_out_n1), .oe_in_n(oe_in_n1), .busy(busy1), .err_watchdog(err1));

    // ---------------- behavioural model ----------------
    // phase: 0 = no path, 1 = waiting out dead time, 2 = path granted
    int         m_phase[2];
    int         m_wait[2];
    int         m_age[2];
    bit         m_dir_out[2];
    bit         m_prio_out[2];
    bit         m_lock[2];
    bit         m_err[2];
    logic [3:0] m_mask[2];
    int         dead_of[2] = '{2, 0};
    bit         model_live = 1'b0;

    task automatic model_step(input int i);
        bit out_ok, take_out, forced;
        m_err[i] = 1'b0;
        forced   = 1'b0;
        if (sys_rst) begin
            m_phase[i] = 0; m_wait[i] = 0; m_age[i] = 0;
            m_dir_out[i] = 1'b1; m_prio_out[i] = 1'b1; m_lock[i] = 1'b0;
            m_mask[i] = 4'h0;
            return;
        end
        case (m_phase[i])
            0: begin
                out_ok = req_out && (lane_mask != 4'h0) && !m_lock[i];
                if (out_ok || req_in) begin
                    take_out     = out_ok && (!req_in || m_prio_out[i]);
                    m_dir_out[i] = take_out;
                    m_mask[i]    = take_out ? lane_mask : 4'hF;
                    if (dead_of[i] == 0) begin
                        m_phase[i] = 2; m_age[i] = 1;
                    end else begin
                        m_phase[i] = 1; m_wait[i] = dead_of[i];
                    end
                end
            end
            1: begin
                if (m_dir_out[i] ? !req_out : !req_in) begin
                    m_phase[i] = 0;
                end else begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) begin
                        m_phase[i] = 2; m_age[i] = 1;
                    end
                end
            end
            default: begin
                if (WD_EN && m_dir_out[i] && m_age[i] == MAXD) forced = 1'b1;
                if (forced || (m_dir_out[i] ? !req_out : !req_in)) begin
                    m_phase[i]    = 0;
                    m_prio_out[i] = !m_prio_out[i];
                end else begin
                    m_age[i]++;
                end
            end
        endcase
        m_err[i] = forced;
        if (forced) m_lock[i] = 1'b1;
        else if (!req_out) m_lock[i] = 1'b0;
    endtask

    function automatic logic [11:0] model_vec(input int i);
        logic g_o, g_i;
        g_o = (m_phase[i] == 2) && m_dir_out[i];
        g_i = (m_phase[i] == 2) && !m_dir_out[i];
        return {g_o, g_i, (g_o ? ~m_mask[i] : 4'hF), (g_i ? 4'h0 : 4'hF),
                (m_phase[i] != 0), m_err[i]};
    endfunction

    always @(posedge sys_clk) begin
        model_step(0);
        model_step(1);
        if (sys_rst) model_live = 1'b1;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Vector order: gnt_out, gnt_in, oe_out_n, oe_in_n, busy, err_watchdog
    always @(negedge sys_clk) begin
        if (model_live) begin
            check("model_dut0", {gnt_out0, gnt_in0, oe_out_n0, oe_in_n0, busy0, err0}, model_vec(0));
            check("model_dut1", {gnt_out1, gnt_in1, oe_out_n1, oe_in_n1, busy1, err1}, model_vec(1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    typedef struct {
        bit       ro;
        bit       ri;
        bit [3:0] m;
        int       hold;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b1, 1'b0, 4'b1010, 5}, '{1'b1, 1'b1, 4'b1010, 6}, '{1'b0, 1'b1, 4'b0000, 3},
        '{1'b1, 1'b1, 4'b0101, 7}, '{1'b0, 1'b0, 4'b0000, 3}, '{1'b1, 1'b0, 4'b1000, 2},
        '{1'b0, 1'b0, 4'b0000, 1}, '{1'b1, 1'b0, 4'b0100, 6}, '{0, 1'b1, 4'b1111, 1},
        '{1'b0, 1'b0, 4'b0000, 3}};

    initial begin
        int n_g0, n_e0, n_g1, n_e1;

        sys_rst = 1'b1;
        tick(2);
        check("reset_dut0", {gnt_out0, gnt_in0, oe_out_n0, oe_in_n0, busy0, err0}, 12'b0_0_1111_1111_0_0);
        check("reset_dut1", {gnt_out1, gnt_in1, oe_out_n1, oe_in_n1, busy1, err1}, 12'b0_0_1111_1111_0_0);
        sys_rst = 1'b0;

        // Drive grant latency with lane mask 0011
        req_out = 1'b1; lane_mask = 4'b0011;
        tick(1);
        check("dead0_grant_e1", {gnt_out1, oe_out_n1}, {1'b1, 4'b1100});
        check("dead2_nogrant_e1", {gnt_out0, oe_out_n0, busy0}, {1'b0, 4'b1111, 1'b1});
        tick(1);
        check("dead2_nogrant_e2", {gnt_out0, oe_out_n0}, {1'b0, 4'b1111});
        tick(1);
        check("dead2_grant_e3", {gnt_out0, oe_out_n0, oe_in_n0}, {1'b1, 4'b1100, 4'b1111});
        lane_mask = 4'b1111;
        tick(2);
        check("mask_ignored_in_drive", oe_out_n0, 4'b1100);
        req_out = 1'b0;
        tick(1);
        check("drive_release", {gnt_out0, oe_out_n0, busy0}, {1'b0, 4'b1111, 1'b0});
        tick(2);

        // Tie from reset, turnaround, priority alternation
        sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
        req_out = 1'b1; req_in = 1'b1; lane_mask = 4'hF;
        tick(3);
        check("tie_out_first", {gnt_out0, gnt_in0, oe_out_n0}, {1'b1, 1'b0, 4'b0000});
        req_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("turnaround_all_high", {gnt_in0, oe_out_n0, oe_in_n0}, {1'b0, 4'b1111, 4'b1111});
        end
        tick(1);
        check("turnaround_listen_e4", {gnt_in0, oe_in_n0}, {1'b1, 4'b0000});
        req_in = 1'b0;
        tick(2);
        req_out = 1'b1; req_in = 1'b1;
        tick(3);
        check("tie_after_listen_out", {gnt_out0, gnt_in0}, 2'b10);
        req_out = 1'b0; req_in = 1'b0;
        tick(2);
        req_out = 1'b1; req_in = 1'b1;
        tick(3);
        check("tie_after_drive_in", {gnt_out0, gnt_in0}, 2'b01);
        req_out = 1'b0; req_in = 1'b0;
        tick(2);

        // One-cycle req_in pulse aborts the dead time
        req_in = 1'b1;
        tick(1);
        check("pulse_dead_entered", {busy0, gnt_in0}, 2'b10);
        req_in = 1'b0;
        tick(1);
        check("pulse_aborted", {busy0, gnt_in0, oe_in_n0}, {1'b0, 1'b0, 4'b1111});
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("pulse_no_grant", gnt_in0, 1'b0);
        end

        // Reset while listening
        req_in = 1'b1;
        tick(3);
        check("listen_before_rst", gnt_in0, 1'b1);
        sys_rst = 1'b1;
        tick(1);
        check("rst_in_listen_dut0", {oe_in_n0, gnt_in0, busy0}, {4'b1111, 1'b0, 1'b0});
        check("rst_in_listen_dut1", {oe_in_n1, gnt_in1, busy1}, {4'b1111, 1'b0, 1'b0});
        sys_rst = 1'b0; req_in = 1'b0;
        tick(2);

        // Empty lane mask: outbound request is not valid
        req_out = 1'b1; lane_mask = 4'b0000; req_in = 1'b1;
        tick(1);
        check("empty_mask_listen_e1", {gnt_in1, oe_in_n1, gnt_out1}, {1'b1, 4'b0000, 1'b0});
        tick(3);
        check("empty_mask_no_drive", {gnt_out0, gnt_out1, gnt_in0}, 3'b001);
        req_out = 1'b0; req_in = 1'b0;
        tick(2);

        // Directed vector table, checked by the model
        foreach (vecs[v]) begin
            req_out = vecs[v].ro; req_in = vecs[v].ri; lane_mask = vecs[v].m;
            tick(vecs[v].hold);
        end

`ifdef NUBUS_OE_WATCHDOG_EN
        // Forced drive release and lockout
        sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
        req_out = 1'b1; lane_mask = 4'hF;
        n_g0 = 0; n_e0 = 0; n_g1 = 0; n_e1 = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            n_g0 += int'(gnt_out0); n_e0 += int'(err0);
            n_g1 += int'(gnt_out1); n_e1 += int'(err1);
        end
        check("wd_drive_cycles_dut0", 12'(n_g0), 12'd8);
        check("wd_err_pulses_dut0", 12'(n_e0), 12'd1);
        check("wd_drive_cycles_dut1", 12'(n_g1), 12'd8);
        check("wd_err_pulses_dut1", 12'(n_e1), 12'd1);
        check("wd_lockout_holds", {gnt_out0, gnt_out1, busy0, busy1}, 4'b0000);
        req_out = 1'b0;
        tick(1);
        req_out = 1'b1;
        tick(3);
        check("wd_regrant_after_low", {gnt_out0, gnt_out1}, 2'b11);
        req_out = 1'b0;
        tick(2);
`else
        n_g0 = 0; n_e0 = 0; n_g1 = 0; n_e1 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
